cube_pow: RTL
=============

# cube_pow

Iterative cuber: computes y = x³ for an unsigned WIDTH-bit operand, returning a 3·WIDTH-bit result. It is the forward direction of the integer cube-root unit. Verification uses it to generate cube-root stimulus and to round-trip check results, and datapaths that need a cube use it directly. It uses the same start/busy handshake as the arithmetic blocks. Internally it runs two passes through one shared sequential shift-add multiplier.

## Interface
- WIDTH, 8, operand width in bits; result width is 3·WIDTH.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous and active-high.
- x_bi  in  WIDTH  unsigned operand; sampled only on the accepting edge.
- start_i  in  1  request; accepted only when busy_o is 0.
- busy_o  out  1  1 while a computation is in flight; reset value 0.
- y_bo  out  3·WIDTH  last result; held until the next result is written; reset value 0.

## Operation
- FSM states:
  - IDLE → SQ_GO on start_i=1; latch x_r ← x_bi.
  - SQ_GO → SQ_WAIT unconditionally. Multiplier start is asserted with a = zero-extended x_r and b = x_r.
  - SQ_WAIT holds while mul_busy=1. On mul_busy=0 it goes → CU_WAIT, asserting multiplier start with a = square product (2·WIDTH bits) and b = x_r.
  - CU_WAIT holds while mul_busy=1. On mul_busy=0 it goes → IDLE and writes y_bo ← product (3·WIDTH bits).
- busy_o = (state != IDLE), decoded combinationally from the state register.
- Multiplier start is a combinational decode of state and mul_busy; it is never registered.
- Arithmetic is unsigned with no truncation:
  - square fits 2·WIDTH bits;
  - cube fits 3·WIDTH bits (255³ = 16 581 375 = 0xFD02FF at WIDTH=8).
- start_i while busy_o=1 is ignored. x_bi changes while busy do not affect the result.
- Reset, including mid-operation: state → IDLE, x_r → 0, y_bo → 0, multiplier cleared. busy_o drops asynchronously. The first start after reset release computes normally.

## Timing
- Accepting edge = E0.
  - SQ_GO during E0..E1; the multiplier loads at E1.
  - Square is ready after E1+WIDTH; the cube pass loads at E1+WIDTH+1.
  - Cube is ready after E2+2·WIDTH; y_bo is written and state returns to IDLE at E0 + 2·WIDTH + 3.
- busy_o is high for exactly 2·WIDTH+3 cycles (19 at WIDTH=8). It falls on the same edge that updates y_bo.
- Back-to-back: start_i held high is re-accepted on the first edge with state=IDLE. That edge is one cycle after busy_o falls, so the pipeline-free cadence is 2·WIDTH+4 cycles per result.
- y_bo never changes except at the write edge or at reset.

## Structure
- Package cube_pkg:
  - FSM state encoding constants (IDLE, SQ_GO, SQ_WAIT, CU_WAIT; 2 bits);
  - default WIDTH;
  - result-width expression 3·WIDTH.
- Sub-module shift_add_mul #(AW, BW), one instance sized AW=2·WIDTH, BW=WIDTH.
  - Ports: clk_i, rst_i (async, active-high), start_i, a_bi[AW], b_bi[BW], busy_o, y_bo[AW+BW].
  - On an edge with start_i=1 and busy_o=0 it loads the operands, clears the accumulator, sets count=BW and sets busy_o.
  - Each following edge adds the shifted a when the current b LSB is 1, then shifts.
  - busy_o falls and y_bo holds the product exactly BW edges after load.
  - Its start is ignored while busy.

## Test plan
- Reset, then x_bi=0 with a 1-cycle start_i pulse → busy_o high for 19 cycles, then y_bo=0.
- x_bi=3, start pulse → y_bo=27 on the edge busy_o falls; y_bo holds its old value up to that edge.
- x_bi=255 → y_bo=0xFD02FF. Sweep all 256 inputs and compare against a model x*x*x.
- x_bi=5 accepted; at cycle 4, start_i=1 with x_bi=7 → ignored; y_bo=125 with no extra busy period.
- x_bi=200 accepted; rst_i asserted at cycle 10 → busy_o=0 and y_bo=0 immediately. After release, x_bi=4 → y_bo=64 in 19 cycles.
- start_i held high with x_bi=2 and then 6 → results 8 then 216. The second computation is accepted one cycle after the first busy_o falls.

Source files
------------

// File: rtl/cube_pkg.sv
// Shared definitions for the iterative cuber: FSM encoding, default operand
// width and the result-width helper.
package cube_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SQ_GO   = 2'd1,
        SQ_WAIT = 2'd2,
        CU_WAIT = 2'd3
    } cube_state_t;

    function automatic int res_w(input int w);
        return 3 * w;
    endfunction

endpackage

// File: rtl/cube_pow_if.sv
// Start/busy handshake bundle for cube_pow: operand in, busy and result out.
interface cube_pow_if #(parameter int WIDTH = cube_pkg::WIDTH_DEF);

    logic                                start_i;
    logic [WIDTH-1:0]                    x_bi;
    logic                                busy_o;
    logic [cube_pkg::res_w(WIDTH)-1:0]   y_bo;

    modport master (output start_i, x_bi, input busy_o, y_bo);
    modport slave  (input start_i, x_bi, output busy_o, y_bo);

endinterface

// File: rtl/shift_add_mul.sv
// Sequential unsigned shift-add multiplier: one multiplier bit per cycle,
// product valid BW edges after the operands are loaded.
module shift_add_mul #(
    parameter int AW = 16,
    parameter int BW = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [AW-1:0]      a_bi,
    input  logic [BW-1:0]      b_bi,
    output logic               busy_o,
    output logic [AW+BW-1:0]   y_bo
);

    localparam int PW = AW + BW;
    localparam int CW = $clog2(BW + 1);

    logic [PW-1:0] a_sh;
    logic [PW-1:0] acc;
    logic [BW-1:0] b_sh;
    logic [CW-1:0] cnt;
    logic          busy_r;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy_r <= 1'b0;
        end else if (start_i && !busy_r) begin
            a_sh   <= PW'(a_bi);
            b_sh   <= b_bi;
            acc    <= '0;
            cnt    <= CW'(BW);
            busy_r <= 1'b1;
        end else if (busy_r) begin
            // Accumulate the shifted multiplicand for each set multiplier bit, LSB first.
            if (b_sh[0]) begin
                acc <= acc + a_sh;
            end
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                busy_r <= 1'b0;
            end
        end
    end

    assign busy_o = busy_r;
    assign y_bo   = acc;

endmodule

// File: rtl/cube_pow.sv
// Iterative cuber y = x^3: squares x, then multiplies the square by x, reusing
// a single shift-add multiplier for both passes.
module cube_pow
    import cube_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    cube_pow_if.slave  bus
);

    localparam int AW = 2 * WIDTH;
    localparam int RW = res_w(WIDTH);

    cube_state_t      state_q;
    cube_state_t      state_d;
    logic [WIDTH-1:0] x_r;
    logic [RW-1:0]    y_r;

    logic             mul_start;
    logic [AW-1:0]    mul_a;
    logic             mul_busy;
    logic [RW-1:0]    mul_y;

    shift_add_mul #(
        .AW (AW),
        .BW (WIDTH)
    ) u_mul (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (mul_start),
        .a_bi    (mul_a),
        .b_bi    (x_r),
        .busy_o  (mul_busy),
        .y_bo    (mul_y)
    );

    always_comb begin
        state_d   = state_q;
        mul_start = 1'b0;
        mul_a     = AW'(x_r);
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d = SQ_GO;
                end
            end
            SQ_GO: begin
                mul_start = 1'b1;
                state_d   = SQ_WAIT;
            end
            SQ_WAIT: begin
                // Square is complete: feed it straight back as the multiplicand.
                if (!mul_busy) begin
                    mul_start = 1'b1;
                    mul_a     = mul_y[AW-1:0];
                    state_d   = CU_WAIT;
                end
            end
            CU_WAIT: begin
                if (!mul_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            x_r     <= '0;
            y_r     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.start_i) begin
                x_r <= bus.x_bi;
            end
            if (state_q == CU_WAIT && !mul_busy) begin
                y_r <= mul_y;
            end
        end
    end

    assign bus.busy_o = (state_q != IDLE);
    assign bus.y_bo   = y_r;

endmodule
